// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel produces a registered
// divided clock, a tick at every rising edge, and acks/rejects divisor loads.
module clk_div_multi #(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = 5
) (
   input  logic                    hclkin,
   input  logic                    resetn,
   input  logic [NUM_CH-1:0]       ch_en,
   input  logic                    sync,
   input  logic [NUM_CH*CNT_W-1:0] div_val,
   input  logic [NUM_CH-1:0]       div_load,
   output logic [NUM_CH-1:0]       clkout,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       div_ack,
   output logic [NUM_CH-1:0]       div_err
);

   localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] MinDiv = CNT_W'(2);
   localparam logic [CNT_W-1:0] One    = CNT_W'(1);
   localparam logic [CNT_W:0]   OneW   = (CNT_W+1)'(1);

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : gCh
      logic [CNT_W-1:0] phase_q, phase_d;
      logic [CNT_W-1:0] active_q, active_d;
      logic [CNT_W-1:0] pendVal_q, pendVal_d;
      logic             pend_q, pend_d;
      logic             run_q;
      logic             clkout_q, clkout_d;
      logic             tick_q, tick_d;
      logic             ack_q, err_q;

      logic [CNT_W-1:0] slice;
      logic [CNT_W:0]   hiCount;
      logic             loadOk, loadBad, wrap, restart, apply;

      // A pending divisor only takes effect where a new period begins (wrap,
      // sync or restart) or while stopped, so no period is ever cut short.
      always_comb begin
         slice    = div_val[gi*CNT_W +: CNT_W];
         loadOk   = div_load[gi] && (slice >= MinDiv);
         loadBad  = div_load[gi] && (slice < MinDiv);
         wrap     = (phase_q == active_q - One);
         restart  = ch_en[gi] && (sync || !run_q || wrap);
         apply    = pend_q && (!ch_en[gi] || restart);

         active_d  = apply ? pendVal_q : active_q;
         pendVal_d = loadOk ? slice : pendVal_q;
         pend_d    = loadOk ? 1'b1 : (apply ? 1'b0 : pend_q);

         phase_d = '0;
         if (ch_en[gi] && !restart) begin
            phase_d = phase_q + One;
         end

         hiCount  = ({1'b0, active_d} + OneW) >> 1;
         clkout_d = ch_en[gi] && ({1'b0, phase_d} < hiCount);
         tick_d   = ch_en[gi] && (phase_d == '0);
      end

      always_ff @(posedge hclkin or negedge resetn) begin
         if (!resetn) begin
            phase_q   <= '0;
            active_q  <= DefDiv;
            pendVal_q <= '0;
            pend_q    <= 1'b0;
            run_q     <= 1'b0;
            clkout_q  <= 1'b0;
            tick_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
         end else begin
            phase_q   <= phase_d;
            active_q  <= active_d;
            pendVal_q <= pendVal_d;
            pend_q    <= pend_d;
            run_q     <= ch_en[gi];
            clkout_q  <= clkout_d;
            tick_q    <= tick_d;
            ack_q     <= apply;
            err_q     <= loadBad;
         end
      end

      assign clkout[gi]  = clkout_q;
      assign tick[gi]    = tick_q;
      assign div_ack[gi] = ack_q;
      assign div_err[gi] = err_q;
   end

endmodule
